param_counter: RTL
==================

PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, minimum 2.
REQ-002 Parameter STEP_W, default 4: width of delta.
REQ-003 Parameter FREQ_W, default 20: width of freq_out.
REQ-004 Parameter GATE_CYCLES, default 1000: measurement window length in clk cycles, minimum 2.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 preload  input  1  load pl_data into qout this cycle.
REQ-008 en  input  1  count enable.
REQ-009 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-010 sat  input  1  mode: 1 = saturate at limits, 0 = modular wrap.
REQ-011 delta  input  STEP_W  unsigned step size per enabled cycle.
REQ-012 pl_data  input  WIDTH  preload value.
REQ-013 qout  output  WIDTH  registered count.
REQ-014 wrap  output  1  registered one-cycle pulse, high the cycle after a wrap event.
REQ-015 at_max / at_min  output  1 each  combinational flags: qout == all-ones / qout == 0.
REQ-016 freq_out  output  FREQ_W  wrap count of the last completed window.
REQ-017 freq_valid  output  1  one-cycle pulse, high the cycle freq_out updates.

Function
REQ-018 Priority per cycle SHALL be: reset > preload > en > hold.
REQ-019 With preload=1, qout SHALL take pl_data next cycle; wrap SHALL be 0 and no wrap event counted.
REQ-020 With en=1 and sat=0, qout SHALL become (qout ± delta) mod 2^WIDTH, using WIDTH+1-bit internal arithmetic.
REQ-021 A wrap event is carry-out on up or borrow on down, only when en=1, preload=0 and sat=0.
REQ-022 With en=1 and sat=1, qout SHALL clamp to 2^WIDTH-1 on up-overflow or 0 on down-underflow; no wrap event.
REQ-023 delta=0 with en=1 SHALL hold qout with no wrap event.
REQ-024 Window counter SHALL run every non-reset cycle, independent of en and preload, counting 0..GATE_CYCLES-1 then returning to 0.
REQ-025 The wrap accumulator SHALL increment per wrap event and saturate at 2^FREQ_W-1.
REQ-026 In the cycle the window counter equals GATE_CYCLES-1, freq_out SHALL load accumulator plus that cycle's event (saturating) and the accumulator SHALL clear; freq_valid SHALL pulse the next cycle.
REQ-027 Preload or a change of sat or up_dn mid-window SHALL NOT restart the window or clear the accumulator.

Reset
REQ-028 Reset SHALL clear qout, wrap, freq_out, freq_valid, accumulator and window counter to 0 on the next edge.
REQ-029 Reset asserted mid-window SHALL discard the partial count; the first window SHALL start the first cycle reset is low.

Configuration
REQ-030 With macro PARAM_COUNTER_FREQ_EN defined, frequency measurement (REQ-024..027) SHALL be built.
REQ-031 Without it, freq_out and freq_valid SHALL be tied to 0 and no window or accumulator logic SHALL exist; all other behaviour is unchanged.

Structure
REQ-032 Package param_counter_pkg SHALL hold default parameter constants and a direction enum (DIR_DOWN=0, DIR_UP=1).
REQ-033 Window counter and accumulator SHALL live in sub-module param_counter_freq_meter, taking a wrap-event strobe and instantiated only under PARAM_COUNTER_FREQ_EN.

Verification
REQ-034 Defaults with macro defined; reset 3 cycles, then up, delta=6, en=1, sat=0 for 3000 cycles -> qout = 6k mod 256 after k cycles; freq_valid pulses at cycles 1001/2001/3001; freq_out = 23 at the first pulse.
REQ-035 Preload 5, then down, delta=6, sat=0 -> qout=255, wrap pulses once; same with sat=1 -> qout=0, at_min=1, no wrap.
REQ-036 Preload 250, then up, delta=15, sat=1 -> qout=255, at_max=1; further cycles hold 255.
REQ-037 preload=1 and en=1 together with pl_data=0x80 -> qout=0x80 next cycle, wrap=0.
REQ-038 Reset asserted at window cycle 500 for 2 cycles -> all outputs 0; next freq_valid exactly GATE_CYCLES cycles after reset deasserts.
REQ-039 Build without PARAM_COUNTER_FREQ_EN, rerun REQ-034 stimulus -> identical qout and wrap; freq_out and freq_valid stay 0.

Source files
------------

// File: rtl/param_counter_pkg.sv
// rtl/param_counter_pkg.sv - default parameters and direction type for param_counter
package param_counter_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_STEP_W      = 4;
  localparam int DEF_FREQ_W      = 20;
  localparam int DEF_GATE_CYCLES = 1000;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/param_counter_freq_meter.sv
// rtl/param_counter_freq_meter.sv - gated wrap-event counter producing one count per window
module param_counter_freq_meter
  import param_counter_pkg::*;
#(
  parameter int FREQ_W      = DEF_FREQ_W,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrap_event,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_valid
);

  localparam int CW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CW-1:0] WIN_LAST = CW'(GATE_CYCLES - 1);

  logic [CW-1:0]     win_cnt;
  logic [FREQ_W-1:0] acc;
  logic [FREQ_W-1:0] acc_next;

  // Accumulator plus this cycle's event, sticking at all-ones once full
  always_comb begin
    acc_next = acc;
    if (wrap_event && !(&acc)) begin
      acc_next = acc + FREQ_W'(1);
    end
  end

  // Free-running window; on its last cycle publish the total and start a fresh count
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt    <= '0;
      acc        <= '0;
      freq_out   <= '0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (win_cnt == WIN_LAST) begin
        win_cnt    <= '0;
        acc        <= '0;
        freq_out   <= acc_next;
        freq_valid <= 1'b1;
      end else begin
        win_cnt <= win_cnt + CW'(1);
        acc     <= acc_next;
      end
    end
  end

endmodule

// File: rtl/param_counter.sv
// rtl/param_counter.sv - up/down step counter with wrap/saturate modes; PARAM_COUNTER_FREQ_EN adds wrap-rate measurement
module param_counter
  import param_counter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int STEP_W      = DEF_STEP_W,
  parameter int FREQ_W      = DEF_FREQ_W,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              preload,
  input  logic              en,
  input  logic              up_dn,
  input  logic              sat,
  input  logic [STEP_W-1:0] delta,
  input  logic [WIDTH-1:0]  pl_data,
  output logic [WIDTH-1:0]  qout,
  output logic              wrap,
  output logic              at_max,
  output logic              at_min,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_valid
);

  // One bit wider than the larger operand so carry/borrow is always visible
  localparam int AW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

  dir_e             dir;
  logic [AW-1:0]    q_ext;
  logic [AW-1:0]    d_ext;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    diff;
  logic             overflow;
  logic             underflow;
  logic [WIDTH-1:0] q_next;
  logic             wrap_event;

  assign dir       = dir_e'(up_dn);
  assign q_ext     = AW'(qout);
  assign d_ext     = AW'(delta);
  assign sum       = q_ext + d_ext;
  assign diff      = q_ext - d_ext;
  assign overflow  = |sum[AW-1:WIDTH];
  assign underflow = diff[AW-1];

  // Next count: preload wins over counting; saturate clamps, wrap mode flags the carry/borrow
  always_comb begin
    q_next     = qout;
    wrap_event = 1'b0;
    if (preload) begin
      q_next = pl_data;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (overflow && sat) begin
          q_next = '1;
        end else begin
          q_next     = sum[WIDTH-1:0];
          wrap_event = overflow;
        end
      end else begin
        if (underflow && sat) begin
          q_next = '0;
        end else begin
          q_next     = diff[WIDTH-1:0];
          wrap_event = underflow;
        end
      end
    end
  end

  // Count register and the registered wrap pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      qout <= '0;
      wrap <= 1'b0;
    end else begin
      qout <= q_next;
      wrap <= wrap_event;
    end
  end

  assign at_max = &qout;
  assign at_min = ~|qout;

`ifdef PARAM_COUNTER_FREQ_EN
  param_counter_freq_meter #(
    .FREQ_W      (FREQ_W),
    .GATE_CYCLES (GATE_CYCLES)
  ) u_freq_meter (
    .clk        (clk),
    .reset      (reset),
    .wrap_event (wrap_event),
    .freq_out   (freq_out),
    .freq_valid (freq_valid)
  );
`else
  assign freq_out   = '0;
  assign freq_valid = 1'b0;
`endif

endmodule
